clock_group_reset_sequencer: RTL and testbench
==============================================

# clock_group_reset_sequencer

Generates the clock/reset pair that feeds a clock-group broadcast stage. Synchronizes deassertion of the board-level asynchronous active-low reset, stretches it by a fixed number of cycles, and drives an active-high reset toward the downstream fan-out. Also services a four-phase software/debug reset request handshake that re-pulses the downstream reset without touching the board reset. Sits directly upstream of the broadcast stage, in the same clock domain.

## Interface

Parameters:
- SYNC_STAGES, 3: synchronizer depth for the reset deassertion; legal range 2..4.
- STRETCH_CYCLES, 16: cycles `auto_out_reset` is held after synchronization or a software request; legal range 1..255.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low board reset. Assertion takes effect immediately; deassertion is synchronized internally.
- sw_req  in  1  software reset request, level, synchronous to `clock`, held until `sw_ack`.
- sw_ack  out  1  request completion; held high until `sw_req` is sampled low.
- auto_out_clock  out  1  `clock` passed through combinationally.
- auto_out_reset  out  1  active-high, registered reset toward the broadcast stage.
- rst_active  out  1  high whenever `auto_out_reset` is high; registered, same timing.
- rst_count  out  8  saturating count of completed software resets. Present only with RESET_SEQ_COUNTER_EN.

## Operation

- FSM states and transitions:
  - S_RESET: wait for the synchronizer output to go high. Then load the counter with STRETCH_CYCLES-1 and go to S_STRETCH.
  - S_STRETCH: decrement the counter. At 0, go to S_ACK if a software request is pending, else S_RUN.
  - S_RUN: `auto_out_reset`=0. If `sw_req`=1, set the pending flag, load the counter and go to S_STRETCH.
  - S_ACK: `sw_ack`=1, `auto_out_reset`=0. When `sw_req`=0, clear the pending flag and go to S_RUN.
- `auto_out_reset`=1 in S_RESET and S_STRETCH, 0 in S_RUN and S_ACK.
- `sw_req` is ignored in S_RESET and S_STRETCH-from-power-on. If it is still high on entry to S_RUN, a software sequence starts on the next cycle.
- Reset values (`reset` low): state S_RESET, synchronizer chain all 0, `auto_out_reset`=1, `rst_active`=1, `sw_ack`=0, counter 0, pending flag 0, `rst_count`=0.
- Reset mid-sequence (any state): all state clears immediately. An in-flight handshake is abandoned. If `sw_req` remains high, the handshake re-runs after the power-on sequence.
- `rst_count` increments by 1 on each S_STRETCH→S_ACK transition and saturates at 255. It is not cleared by a software reset.

## Timing

- Power-on: edge 1 is the first rising edge sampling `reset` high. `auto_out_reset` falls after edge SYNC_STAGES+STRETCH_CYCLES+1, and the same edge enters S_RUN.
- Software request: `sw_req` sampled high in S_RUN at edge k.
  - `auto_out_reset` rises after edge k.
  - `auto_out_reset` falls after edge k+STRETCH_CYCLES.
  - `sw_ack` rises on that same edge.
- `sw_ack` falls after the first edge sampling `sw_req` low in S_ACK. The earliest new request is accepted one edge later.
- `auto_out_reset` assertion from `reset` falling is asynchronous, with no clock needed. Deassertion is always synchronous.
- `auto_out_reset`, `rst_active` and `sw_ack` are direct flop outputs with no combinational path from inputs.

## Configuration

- RESET_SEQ_COUNTER_EN defined: `rst_count` port and its 8-bit saturating counter are present.
- RESET_SEQ_COUNTER_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure

- Shared package `clock_reset_pkg` holds:
  - the state enum (S_RESET, S_STRETCH, S_RUN, S_ACK);
  - the counter width constant, 8 bits;
  - the `rst_count` saturation limit.
- One sub-module, `reset_sync`: a SYNC_STAGES-deep flop chain, async-cleared by `reset`, shifting in constant 1. The top instantiates it once and consumes the last stage.

## Test plan

- Power-on, SYNC_STAGES=3, STRETCH_CYCLES=16: release `reset` -> `auto_out_reset` high through edge 19, low after edge 20; `sw_ack`=0 throughout.
- `sw_req` raised in S_RUN at edge k -> `auto_out_reset` high after edge k through edge k+15, low and `sw_ack`=1 after edge k+16. Drop `sw_req` -> `sw_ack`=0 next edge.
- `sw_req` held high from before power-on release -> full power-on sequence, one cycle low, then one software pulse of 16 cycles, then `sw_ack`=1.
- `reset` pulsed low mid-software-stretch (counter=7) -> `auto_out_reset`=1 immediately, `sw_ack`=0. Full power-on timing repeats.
- STRETCH_CYCLES=1: software request -> `auto_out_reset` high for exactly one cycle; `sw_ack` on the following edge.
- RESET_SEQ_COUNTER_EN defined: 260 completed handshakes -> `rst_count` reads 255; a board reset returns it to 0.

Source files
------------

// File: rtl/clock_reset_pkg.sv
// clock_reset_pkg
//   Shared definitions for the clock-group reset sequencer:
//   - seq_state_e   : sequencer FSM states
//   - CNT_W         : width of the stretch counter and of the reset counter
//   - RST_COUNT_MAX : saturation limit of the completed-software-reset counter
package clock_reset_pkg;

   typedef enum logic [1:0] {
      S_RESET   = 2'd0,
      S_STRETCH = 2'd1,
      S_RUN     = 2'd2,
      S_ACK     = 2'd3
   } seq_state_e;

   localparam int CNT_W = 8;

   localparam logic [CNT_W-1:0] RST_COUNT_MAX = 8'd255;

endpackage

// File: rtl/reset_sync.sv
// reset_sync
//   Reset deassertion synchronizer. A SYNC_STAGES-deep flop chain that is
//   cleared asynchronously by the board reset and shifts in a constant 1,
//   so its last stage rises SYNC_STAGES edges after reset is released.
// Ports:
//   clock    in  sole clock
//   reset    in  asynchronous active-low board reset
//   sync_out out last stage of the chain (1 = reset released and synchronized)
module reset_sync #(
   parameter int SYNC_STAGES = 3
) (
   input  logic clock,
   input  logic reset,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// clock_group_reset_sequencer
//   Produces the clock/reset pair for a clock-group broadcast stage. The board
//   reset deassertion is synchronized, then the downstream reset is stretched
//   for STRETCH_CYCLES cycles. A software request re-pulses the downstream
//   reset without touching the board reset.
//
//   Handshake: sw_req is a level held high by the requester until sw_ack is
//   seen high; sw_ack stays high until sw_req is sampled low, after which the
//   next request may be raised (four-phase, req/ack both return to zero).
//
// Ports:
//   clock          in   sole clock
//   reset          in   asynchronous active-low board reset
//   sw_req         in   software reset request (level)
//   sw_ack         out  request completion (registered)
//   auto_out_clock out  clock passed through
//   auto_out_reset out  active-high registered downstream reset
//   rst_active     out  copy of auto_out_reset (registered, same timing)
//   rst_count      out  saturating count of completed software resets,
//                       present only when RESET_SEQ_COUNTER_EN is defined
module clock_group_reset_sequencer
   import clock_reset_pkg::*;
#(
   parameter int SYNC_STAGES    = 3,
   parameter int STRETCH_CYCLES = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sw_req,
   output logic             sw_ack,
   output logic             auto_out_clock,
   output logic             auto_out_reset,
   output logic             rst_active
`ifdef RESET_SEQ_COUNTER_EN
   ,
   output logic [CNT_W-1:0] rst_count
`endif
);

   localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);

   seq_state_e       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             pend, pend_next;
   logic             rst_next;
   logic             ack_next;
   logic             sync_done;

   assign auto_out_clock = clock;

   reset_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_reset_sync (
      .clock    (clock),
      .reset    (reset),
      .sync_out (sync_done)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= S_RESET;
         cnt            <= '0;
         pend           <= 1'b0;
         auto_out_reset <= 1'b1;
         rst_active     <= 1'b1;
         sw_ack         <= 1'b0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         pend           <= pend_next;
         auto_out_reset <= rst_next;
         rst_active     <= rst_next;
         sw_ack         <= ack_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      pend_next  = pend;
      case (state)
         S_RESET: begin
            if (sync_done) begin
               cnt_next   = STRETCH_LOAD;
               state_next = S_STRETCH;
            end
         end
         S_STRETCH: begin
            // pend distinguishes a software pulse from the power-on stretch
            if (cnt == '0) begin
               state_next = pend ? S_ACK : S_RUN;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         S_RUN: begin
            if (sw_req) begin
               pend_next  = 1'b1;
               cnt_next   = STRETCH_LOAD;
               state_next = S_STRETCH;
            end
         end
         S_ACK: begin
            if (!sw_req) begin
               pend_next  = 1'b0;
               state_next = S_RUN;
            end
         end
         default: begin
            state_next = S_RESET;
         end
      endcase
      // Outputs are decoded from the next state so the flops present them
      // in the same cycle the FSM enters that state.
      rst_next = (state_next == S_RESET) || (state_next == S_STRETCH);
      ack_next = (state_next == S_ACK);
   end

`ifdef RESET_SEQ_COUNTER_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rst_count <= '0;
      end else if ((state == S_STRETCH) && (state_next == S_ACK) &&
                   (rst_count != RST_COUNT_MAX)) begin
         rst_count <= rst_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// tb_clock_group_reset_sequencer
//   Directed bench for clock_group_reset_sequencer. Instance u0 uses the
//   default parameters (3 sync stages, 16 stretch cycles); instance u1 uses
//   STRETCH_CYCLES=1. Inputs change on the falling edge; outputs are checked
//   on the falling edge after each rising edge. The rst_count checks exist
//   only when RESET_SEQ_COUNTER_EN is defined.
`timescale 1ns/1ps
module tb_clock_group_reset_sequencer;

   logic clock;
   logic reset0, req0, ack0, oclk0, orst0, act0;
   logic reset1, req1, ack1, oclk1, orst1, act1;
`ifdef RESET_SEQ_COUNTER_EN
   logic [7:0] cnt0, cnt1;
`endif

   int total;
   int bad;

   // ---------------- clock / reset block ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   clock_group_reset_sequencer #(
      .SYNC_STAGES(3), .STRETCH_CYCLES(16)
   ) u0 (
      .clock          (clock),
      .reset          (reset0),
      .sw_req         (req0),
      .sw_ack         (ack0),
      .auto_out_clock (oclk0),
      .auto_out_reset (orst0),
      .rst_active     (act0)
`ifdef RESET_SEQ_COUNTER_EN
      ,
      .rst_count      (cnt0)
`endif
   );

   clock_group_reset_sequencer #(
      .SYNC_STAGES(3), .STRETCH_CYCLES(1)
   ) u1 (
      .clock          (clock),
      .reset          (reset1),
      .sw_req         (req1),
      .sw_ack         (ack1),
      .auto_out_clock (oclk1),
      .auto_out_reset (orst1),
      .rst_active     (act1)
`ifdef RESET_SEQ_COUNTER_EN
      ,
      .rst_count      (cnt1)
`endif
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance one rising edge and land on the following falling edge.
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // One full four-phase handshake on u0 with bounded waits.
   task automatic handshake0();
      bit seen;
      req0 = 1'b1;
      seen = 1'b0;
      for (int j = 0; j < 100; j++) begin
         tick();
         if (ack0) begin
            seen = 1'b1;
            break;
         end
      end
      check("hs_ack_rise", {31'd0, seen}, 32'd1);
      req0 = 1'b0;
      tick();
      check("hs_ack_fall", {31'd0, ack0}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      total  = 0;
      bad    = 0;
      reset0 = 1'b0;
      req0   = 1'b0;
      reset1 = 1'b0;
      req1   = 1'b0;
      @(negedge clock);
      repeat (3) tick();

      // Reset values
      check("rv_rst0", {31'd0, orst0}, 32'd1);
      check("rv_act0", {31'd0, act0},  32'd1);
      check("rv_ack0", {31'd0, ack0},  32'd0);
      check("rv_rst1", {31'd0, orst1}, 32'd1);
      check("rv_ack1", {31'd0, ack1},  32'd0);
      check("clk_pass0", {31'd0, oclk0}, 32'd0);
      check("clk_pass1", {31'd0, oclk1}, 32'd0);
`ifdef RESET_SEQ_COUNTER_EN
      check("rv_cnt0", {24'd0, cnt0}, 32'd0);
`endif

      // Power-on: downstream reset high through edge 19, low after edge 20
      reset0 = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         check("po_rst", {31'd0, orst0}, {31'd0, (n < 20)});
         check("po_act", {31'd0, act0},  {31'd0, (n < 20)});
         check("po_ack", {31'd0, ack0},  32'd0);
      end

      // Software request sampled at edge k (first tick below)
      req0 = 1'b1;
      for (int n = 0; n <= 16; n++) begin
         tick();
         check("sw_rst", {31'd0, orst0}, {31'd0, (n < 16)});
         check("sw_ack", {31'd0, ack0},  {31'd0, (n == 16)});
      end
      req0 = 1'b0;
      tick();
      check("sw_ack_drop", {31'd0, ack0},  32'd0);
      check("sw_rst_idle", {31'd0, orst0}, 32'd0);

      // New request accepted on the very next edge
      req0 = 1'b1;
      tick();
      check("sw2_accept", {31'd0, orst0}, 32'd1);
      for (int n = 1; n <= 8; n++) tick();
      check("sw2_mid", {31'd0, orst0}, 32'd1);

      // Board reset mid-stretch (counter = 7): immediate, asynchronous
      reset0 = 1'b0;
      #1;
      check("mid_rst", {31'd0, orst0}, 32'd1);
      check("mid_act", {31'd0, act0},  32'd1);
      check("mid_ack", {31'd0, ack0},  32'd0);

      // Release with sw_req still high: power-on, one low cycle, 16-cycle pulse
      @(negedge clock);
      reset0 = 1'b1;
      for (int n = 1; n <= 37; n++) begin
         tick();
         check("held_rst", {31'd0, orst0},
               {31'd0, ((n < 20) || ((n >= 21) && (n < 37)))});
         check("held_ack", {31'd0, ack0}, {31'd0, (n == 37)});
      end
      tick();
      check("held_ack_hold", {31'd0, ack0}, 32'd1);
      req0 = 1'b0;
      tick();
      check("held_ack_drop", {31'd0, ack0}, 32'd0);

      // STRETCH_CYCLES=1: power-on ends after edge 5
      reset1 = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         tick();
         check("s1_po_rst", {31'd0, orst1}, {31'd0, (n < 5)});
      end
      req1 = 1'b1;
      tick();
      check("s1_rst_hi", {31'd0, orst1}, 32'd1);
      check("s1_ack_lo", {31'd0, ack1},  32'd0);
      tick();
      check("s1_rst_lo", {31'd0, orst1}, 32'd0);
      check("s1_ack_hi", {31'd0, ack1},  32'd1);
      req1 = 1'b0;
      tick();
      check("s1_ack_drop", {31'd0, ack1}, 32'd0);

`ifdef RESET_SEQ_COUNTER_EN
      // Counter saturation and clear by board reset
      reset0 = 1'b0;
      #1;
      check("cnt_clr0", {24'd0, cnt0}, 32'd0);
      @(negedge clock);
      reset0 = 1'b1;
      repeat (20) tick();
      for (int i = 1; i <= 260; i++) begin
         handshake0();
         if (i == 1)   check("cnt_1",   {24'd0, cnt0}, 32'd1);
         if (i == 255) check("cnt_255", {24'd0, cnt0}, 32'd255);
         if (i == 260) check("cnt_sat", {24'd0, cnt0}, 32'd255);
      end
      reset0 = 1'b0;
      #1;
      check("cnt_clr1", {24'd0, cnt0}, 32'd0);
      @(negedge clock);
      reset0 = 1'b1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
